// File: rtl/linescanner_pkg.sv
// Shared types and widths for the line-scanner capture path.
package linescanner_pkg;

    localparam int unsigned PIXEL_WIDTH = 8;
    localparam int unsigned WORD_WIDTH  = 32;
    localparam int unsigned LANES       = WORD_WIDTH / PIXEL_WIDTH;
    localparam int unsigned COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    typedef struct packed {
        logic                  last;
        logic [WORD_WIDTH-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/linescanner_line_packer_if.sv
// Packed-word output stream: valid/ready with end-of-line marker.
interface linescanner_line_packer_if;
    import linescanner_pkg::*;

    logic [WORD_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (output m_data, output m_valid, output m_last, input  m_ready);
    modport slave  (input  m_data, input  m_valid, input  m_last, output m_ready);

endinterface

// File: rtl/linescanner_word_fifo.sv
// Synchronous first-word-fall-through FIFO; a write when full is taken if a read happens the same cycle.
module linescanner_word_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 33
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    // Head is masked while empty so the output reads zero after reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/linescanner_line_packer.sv
// Frames the pixel stream into lines and packs four pixels per word into a FIFO-backed output stream.
module linescanner_line_packer
    import linescanner_pkg::*;
#(
    parameter int unsigned LINE_LENGTH = 1024,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          line_valid,
    input  logic [PIXEL_WIDTH-1:0]        pixel_data,
    input  logic                          pixel_captured,
    input  logic                          clear_status,
    linescanner_line_packer_if.master     m_if,
    output logic                          busy,
    output logic                          overflow,
    output logic                          line_error,
    output logic [COUNT_WIDTH-1:0]        dropped_words
);

    state_t                              state, state_n;
    logic [1:0]                          lane, lane_n;
    logic [COUNT_WIDTH-1:0]              count, count_n;
    logic [LANES-1:0][PIXEL_WIDTH-1:0]   lane_buf, lane_buf_n;
    logic                                word_seen, word_seen_n;
    logic                                long_watch, long_watch_n;
    logic                                flush_zero, flush_zero_n;
    logic                                lv_q;

    logic                                push_valid;
    fifo_entry_t                         push_entry;
    logic                                push_c;
    fifo_entry_t                         push_entry_c;
    logic                                error_c;

    logic                                rise;
    logic                                fall;
    logic                                start;
    logic                                in_line;
    logic [1:0]                          lane_cur;
    logic [COUNT_WIDTH-1:0]              count_cur;
    logic [COUNT_WIDTH-1:0]              count_inc;
    logic                                seen_cur;
    logic                                accept;
    logic                                line_done;
    logic                                word_full;
    logic [LANES-1:0][PIXEL_WIDTH-1:0]   word_c;

    logic                                fifo_full;
    logic                                fifo_empty;
    fifo_entry_t                         rd_entry;
    logic                                drop;

    assign rise      = line_valid && !lv_q;
    assign fall      = lv_q && !line_valid;
    // A start cycle behaves as an ACTIVE cycle seen from lane 0 / count 0.
    assign start     = (state == IDLE) && rise && enable;
    assign in_line   = start || (state == ACTIVE);
    assign lane_cur  = start ? 2'd0 : lane;
    assign count_cur = start ? '0 : count;
    assign seen_cur  = start ? 1'b0 : word_seen;
    assign accept    = in_line && pixel_captured;
    assign count_inc = count_cur + COUNT_WIDTH'(1);
    assign line_done = accept && (count_inc == COUNT_WIDTH'(LINE_LENGTH));
    assign word_full = accept && (lane_cur == 2'd3);

    // Word as it stands after this cycle's pixel; unfilled lanes read zero.
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            if (2'(i) < lane_cur) begin
                word_c[i] = lane_buf[i];
            end else if (accept && (2'(i) == lane_cur)) begin
                word_c[i] = pixel_data;
            end else begin
                word_c[i] = '0;
            end
        end
    end

    always_comb begin
        state_n           = state;
        lane_n            = lane;
        count_n           = count;
        lane_buf_n        = lane_buf;
        word_seen_n       = word_seen;
        long_watch_n      = line_valid ? long_watch : 1'b0;
        flush_zero_n      = 1'b0;
        push_c            = 1'b0;
        push_entry_c      = '0;
        error_c           = 1'b0;

        case (state)
            IDLE: begin
                if (long_watch && line_valid && pixel_captured) begin
                    error_c = 1'b1;
                end
            end
            FLUSH: begin
                state_n = IDLE;
                if (flush_zero) begin
                    push_c            = 1'b1;
                    push_entry_c.last = 1'b1;
                end
            end
            default: ;
        endcase

        if (in_line) begin
            state_n     = ACTIVE;
            lane_n      = lane_cur;
            count_n     = count_cur;
            word_seen_n = seen_cur;
            if (accept) begin
                lane_buf_n[lane_cur] = pixel_data;
                lane_n               = lane_cur + 2'd1;
                count_n              = count_inc;
            end
            if (word_full) begin
                push_c            = 1'b1;
                push_entry_c.last = line_done;
                push_entry_c.data = word_c;
                word_seen_n       = 1'b1;
            end
            if (line_done) begin
                state_n      = IDLE;
                long_watch_n = line_valid;
            end else if (fall) begin
                // Short line: close it out so the consumer always sees a last word.
                state_n = FLUSH;
                error_c = 1'b1;
                if (lane_n != 2'd0) begin
                    push_c            = 1'b1;
                    push_entry_c.last = 1'b1;
                    push_entry_c.data = word_c;
                end else if (word_full) begin
                    flush_zero_n = 1'b1;
                end else if (seen_cur) begin
                    push_c            = 1'b1;
                    push_entry_c.last = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lane       <= '0;
            count      <= '0;
            lane_buf   <= '0;
            word_seen  <= 1'b0;
            long_watch <= 1'b0;
            flush_zero <= 1'b0;
            lv_q       <= 1'b0;
            push_valid <= 1'b0;
            push_entry <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            lane       <= lane_n;
            count      <= count_n;
            lane_buf   <= lane_buf_n;
            word_seen  <= word_seen_n;
            long_watch <= long_watch_n;
            flush_zero <= flush_zero_n;
            lv_q       <= line_valid;
            push_valid <= push_c;
            push_entry <= push_entry_c;
            busy       <= (state_n != IDLE);
        end
    end

    assign drop = push_valid && fifo_full && !m_if.m_ready;

    // Sticky status; a clear wins over a same-cycle set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow      <= 1'b0;
            line_error    <= 1'b0;
            dropped_words <= '0;
        end else if (clear_status) begin
            overflow      <= 1'b0;
            line_error    <= 1'b0;
            dropped_words <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
                if (dropped_words != {COUNT_WIDTH{1'b1}}) begin
                    dropped_words <= dropped_words + COUNT_WIDTH'(1);
                end
            end
            if (error_c) begin
                line_error <= 1'b1;
            end
        end
    end

    linescanner_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fifo_entry_t))
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (push_valid),
        .wr_data (push_entry),
        .full    (fifo_full),
        .rd_en   (m_if.m_ready),
        .rd_data (rd_entry),
        .empty   (fifo_empty)
    );

    assign m_if.m_valid = !fifo_empty;
    assign m_if.m_data  = rd_entry.data;
    assign m_if.m_last  = rd_entry.last;

endmodule

// File: doc/linescanner_line_packer.md
# linescanner_line_packer

Downstream stage of the line-scanner capture unit. Consumes the 8-bit pixel stream and its per-pixel strobe, frames it into lines using the sensor line-valid signal, and packs four pixels per 32-bit word. Packed words pass through a small FIFO to a valid/ready output stream with end-of-line marking, which feeds the DMA/frame-store stage. Overflow and malformed-line conditions are reported as sticky status.

## Interface

Parameters:
- LINE_LENGTH, 1024: pixels per nominal line; multiple of 4, range 4..65532.
- FIFO_DEPTH, 16: FIFO depth in words; power of 2, at least 4.

Ports:
- clock  in  1  single clock for the whole block; pixel inputs are already synchronous to it.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  permits a new line to start; sampled only in IDLE.
- line_valid  in  1  sensor line-valid, registered upstream; a rising edge starts a line.
- pixel_data  in  8  pixel value; qualified by pixel_captured.
- pixel_captured  in  1  one-cycle strobe; one pixel per strobe.
- clear_status  in  1  synchronous clear of the sticky flags and dropped_words.
- m_data  out  32  packed word; the first pixel of each group is in bits [7:0], the fourth in [31:24].
- m_valid  out  1  output word available.
- m_ready  in  1  consumer accepts; a transfer occurs when m_valid and m_ready are both high.
- m_last  out  1  word is the final word of its line.
- busy  out  1  high when the state is not IDLE.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- line_error  out  1  sticky: a short line or a long line occurred.
- dropped_words  out  16  count of dropped words; saturates at 0xFFFF.

## Operation

- States are IDLE, ACTIVE and FLUSH. A 2-bit lane index and a 16-bit pixel counter track progress through the line.
- Line-valid rising edge is detected against a registered copy of line_valid.
- IDLE to ACTIVE: a rising edge of line_valid with enable high. A pixel strobe on the same cycle is accepted as pixel 0.
- Outside ACTIVE, pixel strobes are ignored. Rising edges with enable low are ignored, and that line is skipped entirely.
- In ACTIVE, each strobe writes pixel_data into the current lane and increments the lane and the pixel counter.
  - When lane 3 fills, the word is pushed to the FIFO with last set if the counter reaches LINE_LENGTH.
  - When the counter reaches LINE_LENGTH, the state goes to IDLE.
- Short line: line_valid falls while the counter is below LINE_LENGTH.
  - Go to FLUSH.
  - If the lane index is not 0, push the partial word with unused lanes set to zero and last set.
  - If the lane index is 0 and at least one word has been pushed, push an all-zero word with last set, so that every line ends with a last word.
  - If no pixel was received, push nothing.
  - Set line_error, then go to IDLE after one cycle.
- A pixel strobe on the same cycle as the line_valid falling edge is accepted before the flush.
- Long line: strobes after LINE_LENGTH while line_valid is still high are ignored, and line_error is set. A new line requires a fresh rising edge.
- FIFO full at push time: the word is dropped, overflow is set, and dropped_words increments. The line state advances as normal, so a dropped last word means that line has no m_last.
- clear_status has priority over a set of a flag on the same cycle.
- Deasserting enable mid-line has no effect until the line ends.

## Timing

- Reset values:
  - m_valid, m_last, busy, overflow and line_error are 0.
  - m_data and dropped_words are 0.
  - The state is IDLE, and the counter and lane index are 0.
- Packing latency: a 4th-lane strobe at cycle N gives a FIFO write at N+1 and m_valid high at N+2 (first-word-fall-through).
- Flush latency: a line_valid falling edge observed at cycle N gives a partial-word write at N+1 and m_valid at N+2.
- The FIFO may read and write on the same cycle, and may write when full if it also reads on that cycle; in that case no drop occurs.
- m_data and m_last hold stable while m_valid is high and m_ready is low.
- Sustained throughput is one word per cycle on output. Input may arrive at one pixel per cycle.
- Reset mid-line discards the partial word and the FIFO contents. m_valid falls immediately (asynchronously).

## Structure

- Shared package, linescanner_pkg:
  - PIXEL_WIDTH = 8 and WORD_WIDTH = 32.
  - The state enum (IDLE, ACTIVE, FLUSH).
  - A packed struct of {last, data} for FIFO entries.
- Sub-module linescanner_word_fifo: synchronous, first-word-fall-through, width 33, depth FIFO_DEPTH, with full/empty outputs. It is reused by other capture-path stages.
- The packer FSM, lane register, counter and status logic live in the top module.

## Test plan

- Nominal line: LINE_LENGTH=8, pixels 0x01..0x08, m_ready=1. Expect two words, 0x04030201 and then 0x08070605 with m_last=1. line_error stays 0.
- Short line: 6 pixels 0xA0..0xA5, then line_valid falls. Expect 0xA3A2A1A0, then 0x0000A5A4 with m_last=1, and line_error=1.
- Long line: LINE_LENGTH=4, 6 strobes with 0x10..0x15. Expect exactly one word, 0x13121110 with m_last=1; extra pixels ignored; line_error=1.
- Backpressure overflow: FIFO_DEPTH=4, m_ready=0, 24 pixels. Expect 4 words held, overflow=1 and dropped_words=2. After m_ready=1, words 0..3 drain in order. clear_status then gives 0/0.
- Enable and reset: a line starting with enable=0 produces no output. Reset asserted mid-line with 2 pixels pending gives m_valid=0 and busy=0 immediately, and the next line packs from lane 0.
